state_dump_module: RTL and testbench

- Read-back counterpart to INITIAL_MODULE. INITIAL_MODULE writes initial contents into BTB, BHT and the register file; this block reads those same structures back after a run.
- On a start edge, sweeps the register file, then the BHT, then the BTB. Streams every entry out as a tagged beat over a valid/ready interface to a downstream sink (UART TX or LED/debug shim on the FPGA board).
- Sits beside TOPCPU, driving the read-side address ports of the three structures.

---
 rtl/state_dump_module.sv | 169 ++++++++++++++++
 tb/tb_state_dump_module.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_module.sv
// state_dump_module
// Read-back companion of the initial-contents loader. On a rising edge of
// i_start it sweeps the register file, then the BHT, then the BTB. Every entry
// is streamed out as one tagged beat over a valid/ready interface.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            asynchronous active-low reset
//   i_start          dump request level; only its rising edge is acted on
//   i_reg_rdata      register-file read data for o_dump_reg_addr (combinational)
//   i_bht_rdata      BHT read data for o_dump_bht_addr (combinational)
//   i_btb_rdata      BTB read data for o_dump_btb_addr (combinational)
//   o_dump_reg_addr  register-file read address (idx while sweeping REG, else 0)
//   o_dump_bht_addr  BHT read address (idx while sweeping BHT, else 0)
//   o_dump_btb_addr  BTB read address (idx while sweeping BTB, else 0)
//   o_out_valid      o_out_data holds a beat
//   i_out_ready      sink accepts the beat when valid & ready at a rising edge
//   o_out_data       beat {sel[1:0], index[7:0], payload[39:0]}
//   o_busy           sweep in progress
//   o_done           sweep complete, held until i_start is seen low
module state_dump_module #(
  parameter int unsigned REG_DEPTH = 32,
  parameter int unsigned BHT_DEPTH = 256,
  parameter int unsigned BTB_DEPTH = 256,
  parameter int unsigned REG_W     = 32,
  parameter int unsigned BHT_W     = 2,
  parameter int unsigned BTB_W     = 40,
  localparam int unsigned REG_AW   = $clog2(REG_DEPTH),
  localparam int unsigned BHT_AW   = $clog2(BHT_DEPTH),
  localparam int unsigned BTB_AW   = $clog2(BTB_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [REG_W-1:0]  i_reg_rdata,
  input  logic [BHT_W-1:0]  i_bht_rdata,
  input  logic [BTB_W-1:0]  i_btb_rdata,
  output logic [REG_AW-1:0] o_dump_reg_addr,
  output logic [BHT_AW-1:0] o_dump_bht_addr,
  output logic [BTB_AW-1:0] o_dump_btb_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [49:0]       o_out_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned IdxW     = 8;
  localparam int unsigned PayloadW = 40;

  typedef enum logic [2:0] {
    StIdle,
    StReg,
    StBht,
    StBtb,
    StDrain,
    StDone
  } state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_idx;
  logic                r_start_q;
  logic                r_out_valid;
  logic [49:0]         r_out_data;
  logic                r_busy;
  logic                r_done;

  logic                w_start_edge;
  logic                w_load;
  logic                w_last;
  logic [1:0]          w_sel;
  logic [PayloadW-1:0] w_payload;
  state_e              w_next_section;

  assign w_start_edge = i_start & ~r_start_q;
  // The output register may be refilled when empty or when its beat is being taken.
  assign w_load       = ~r_out_valid | i_out_ready;

  // Per-section beat contents and end-of-section detection.
  always_comb begin
    w_payload      = '0;
    w_sel          = 2'b00;
    w_last         = 1'b0;
    w_next_section = r_state;
    case (r_state)
      StReg: begin
        w_payload[REG_W-1:0] = i_reg_rdata;
        w_sel                = 2'b00;
        w_last               = (r_idx == IdxW'(REG_DEPTH - 1));
        w_next_section       = StBht;
      end
      StBht: begin
        w_payload[BHT_W-1:0] = i_bht_rdata;
        w_sel                = 2'b01;
        w_last               = (r_idx == IdxW'(BHT_DEPTH - 1));
        w_next_section       = StBtb;
      end
      StBtb: begin
        w_payload[BTB_W-1:0] = i_btb_rdata;
        w_sel                = 2'b10;
        w_last               = (r_idx == IdxW'(BTB_DEPTH - 1));
        w_next_section       = StDrain;
      end
      default: ;
    endcase
  end

  // Addresses are combinational so the read data matches idx at the load edge.
  assign o_dump_reg_addr = (r_state == StReg) ? r_idx[REG_AW-1:0] : '0;
  assign o_dump_bht_addr = (r_state == StBht) ? r_idx[BHT_AW-1:0] : '0;
  assign o_dump_btb_addr = (r_state == StBtb) ? r_idx[BTB_AW-1:0] : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_start_q   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_start_q <= i_start;
      case (r_state)
        StIdle: begin
          if (w_start_edge) begin
            r_state <= StReg;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StReg, StBht, StBtb: begin
          if (w_load) begin
            r_out_data  <= {w_sel, r_idx, w_payload};
            r_out_valid <= 1'b1;
            if (w_last) begin
              r_idx   <= '0;
              r_state <= w_next_section;
            end else begin
              r_idx <= r_idx + IdxW'(1);
            end
          end
        end
        StDrain: begin
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StDone;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        StDone: begin
          // Level low is required before another edge can start a new sweep.
          if (!i_start) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_state_dump_module.sv
// Testbench for state_dump_module: scoreboard of expected beats fed by the
// stimulus process, drained by an independent monitor on accepted handshakes.
module tb_state_dump_module;

  localparam int NBEATS = 544;
  localparam int LOGSZ  = 4096;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] reg_rdata;
  logic [1:0]  bht_rdata;
  logic [39:0] btb_rdata;
  logic [4:0]  dump_reg_addr;
  logic [7:0]  dump_bht_addr;
  logic [7:0]  dump_btb_addr;
  logic        out_valid;
  logic        out_ready;
  logic [49:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] reg_mem [32];
  logic [1:0]  bht_mem [256];
  logic [39:0] btb_mem [256];

  assign reg_rdata = reg_mem[dump_reg_addr];
  assign bht_rdata = bht_mem[dump_bht_addr];
  assign btb_rdata = btb_mem[dump_btb_addr];

  state_dump_module dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_reg_rdata     (reg_rdata),
    .i_bht_rdata     (bht_rdata),
    .i_btb_rdata     (btb_rdata),
    .o_dump_reg_addr (dump_reg_addr),
    .o_dump_bht_addr (dump_bht_addr),
    .o_dump_btb_addr (dump_btb_addr),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_data      (out_data),
    .o_busy          (busy),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  logic [49:0] exp_q[$];
  logic [49:0] got_log [LOGSZ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  // Expected beat k of a sweep, written out from the preload pattern.
  function automatic logic [49:0] exp_beat(input int k);
    logic [7:0]  j;
    logic [31:0] w;
    if (k < 32) begin
      j = 8'(k);
      w = 32'(k) * 32'h0101_0101;
      return {2'b00, j, 8'h00, w};
    end else if (k < 288) begin
      j = 8'(k - 32);
      return {2'b01, j, 38'h0, j[1:0]};
    end else begin
      j = 8'(k - 288);
      return {2'b10, j, j, 32'hA5A5_0000 | {24'h0, j}};
    end
  endfunction

  task automatic push_sweep();
    for (int k = 0; k < NBEATS; k++) exp_q.push_back(exp_beat(k));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a beat is taken at the next rising edge when valid & ready are seen here.
  initial begin
    logic [49:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (acc_cnt < LOGSZ) got_log[acc_cnt] = out_data;
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got=%0h expected=none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL beat_%0d got=%0h expected=%0h", acc_cnt - 1, out_data, e);
          end
        end
      end
    end
  end

  initial begin
    int          n;
    int          base;
    int          pulsed;
    bit          stalled;
    logic [49:0] snap_data;
    logic [4:0]  snap_reg;
    logic [7:0]  snap_bht;

    clk = 1'b0; rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) reg_mem[i] = 32'(i) * 32'h0101_0101;
    for (int i = 0; i < 256; i++) begin
      bht_mem[i] = 2'(i % 4);
      btb_mem[i] = {8'(i), 32'hA5A5_0000 | 32'(i)};
    end

    // Reset values
    #2 rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_reg_addr", dump_reg_addr, 0);
    check("rst_bht_addr", dump_bht_addr, 0);
    check("rst_btb_addr", dump_btb_addr, 0);
    step(); step();
    rst = 1'b1;
    step();

    // Full sweep, ready always high, start pulsed
    out_ready = 1'b1;
    base = acc_cnt;
    push_sweep();
    start = 1'b1;
    n = 0;
    do begin
      step(); n++;
      if (n == 1) begin
        check("busy_after_edge", busy, 1);
        check("valid_after_edge", out_valid, 0);
        start = 1'b0;
      end
      if (n == 2) check("first_beat_latency", out_valid, 1);
    end while (!done && n < 2000);
    check("done_latency", n, 546);
    check("busy_at_done", busy, 0);
    check("valid_at_done", out_valid, 0);
    check("beats_run1", acc_cnt - base, NBEATS);
    check("queue_empty_run1", exp_q.size(), 0);
    check("beat0", got_log[base], {2'b00, 8'h00, 40'h0});
    check("beat32", got_log[base + 32], {2'b01, 8'h00, 40'h0});
    check("beat287", got_log[base + 287], {2'b01, 8'hFF, 40'h3});
    check("beat288", got_log[base + 288], {2'b10, 8'h00, 40'h00_A5A5_0000});
    step();
    check("done_clears_run1", done, 0);

    // Backpressure on beat 31 across the REG->BHT boundary
    base = acc_cnt;
    push_sweep();
    start = 1'b1;
    stalled = 1'b0;
    n = 0;
    do begin
      step(); n++;
      if (n == 1) start = 1'b0;
      if (!stalled && out_valid && out_data[49:40] == 10'h01F) begin
        out_ready = 1'b0;
        snap_data = out_data;
        snap_reg  = dump_reg_addr;
        snap_bht  = dump_bht_addr;
        for (int s = 0; s < 5; s++) begin
          step(); n++;
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, snap_data);
          check("stall_reg_addr", dump_reg_addr, snap_reg);
          check("stall_bht_addr", dump_bht_addr, snap_bht);
        end
        out_ready = 1'b1;
        stalled = 1'b1;
      end
    end while (!done && n < 2000);
    check("stall_seen", stalled, 1);
    check("stall_beat31", got_log[base + 31], {2'b00, 8'h1F, 40'h00_1F1F_1F1F});
    check("stall_beat32", got_log[base + 32], {2'b01, 8'h00, 40'h0});
    check("beats_run2", acc_cnt - base, NBEATS);
    check("queue_empty_run2", exp_q.size(), 0);
    step();
    check("done_clears_run2", done, 0);

    // Random ready, start held high with an extra re-pulse mid-sweep
    base = acc_cnt;
    push_sweep();
    start = 1'b1;
    pulsed = 0;
    n = 0;
    do begin
      step(); n++;
      out_ready = 1'($urandom_range(0, 1));
      if (pulsed == 0 && acc_cnt - base >= 200) begin
        start = 1'b0;
        pulsed = 1;
      end else if (pulsed == 1) begin
        start = 1'b1;
        pulsed = 2;
      end
    end while (!done && n < 5000);
    check("repulse_issued", pulsed, 2);
    check("beats_run3", acc_cnt - base, NBEATS);
    check("queue_empty_run3", exp_q.size(), 0);
    out_ready = 1'b1;
    repeat (5) step();
    check("done_held_start_high", done, 1);
    check("busy_held_start_high", busy, 0);
    start = 1'b0;
    step();
    check("done_clears_run3", done, 0);
    repeat (3) step();
    check("no_restart_busy", busy, 0);
    check("no_restart_valid", out_valid, 0);

    // Reset mid-sweep at beat 100
    base = acc_cnt;
    push_sweep();
    start = 1'b1;
    n = 0;
    do begin
      step(); n++;
      if (n == 1) start = 1'b0;
    end while (acc_cnt - base < 100 && n < 2000);
    check("beats_before_rst", acc_cnt - base, 100);
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_data", out_data, 0);
    check("midrst_reg_addr", dump_reg_addr, 0);
    check("midrst_bht_addr", dump_bht_addr, 0);
    check("midrst_btb_addr", dump_btb_addr, 0);
    exp_q.delete();
    step(); step();

    // Start edge in the same cycle as reset release
    base = acc_cnt;
    push_sweep();
    rst = 1'b1;
    start = 1'b1;
    n = 0;
    do begin
      step(); n++;
      if (n == 1) start = 1'b0;
    end while (!done && n < 2000);
    check("done_latency_post_rst", n, 546);
    check("beats_run5", acc_cnt - base, NBEATS);
    check("queue_empty_run5", exp_q.size(), 0);
    check("fresh_beat0", got_log[base], {2'b00, 8'h00, 40'h0});
    check("fresh_beat543", got_log[base + 543], {2'b10, 8'hFF, 40'hFF_A5A5_00FF});
    step();
    check("done_clears_run5", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
